// File: rtl/stim_sweep_gen_if.sv
// Stimulus/response bus between the sweep generator and the combinational block under test.
// The master drives vectors and the sample strobe; the slave returns the response.
interface stim_sweep_gen_if #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 3
);
  logic [IN_W-1:0]  stim_out;
  logic             sample_valid;
  logic [OUT_W-1:0] dut_resp;

  modport master (output stim_out, output sample_valid, input dut_resp);
  modport slave  (input stim_out, input sample_valid, output dut_resp);
endinterface

// File: rtl/stim_sweep_gen.sv
// Exhaustive input sweep for a combinational block, compacting each response into a 16-bit MISR.
// Each vector is held HOLD cycles and sampled on the last one; there is no backpressure, only start and rst.
module stim_sweep_gen #(
  parameter int          IN_W  = 6,
  parameter int          OUT_W = 3,
  parameter int          HOLD  = 1,
  parameter logic [15:0] POLY  = 16'h1021
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  stim_sweep_gen_if.master sweep,
  output logic            busy,
  output logic            done,
  output logic [15:0]     signature,
  output logic [IN_W:0]   vec_count
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [IN_W:0]   LAST_IDX  = {1'b0, {IN_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IN_W:0]   idx, idx_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic [15:0]     sig, sig_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      hcnt  <= '0;
      sig   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      hcnt  <= hcnt_nxt;
      sig   <= sig_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    idx_nxt            = idx;
    hcnt_nxt           = hcnt;
    sig_nxt            = sig;
    busy               = 1'b0;
    done               = 1'b0;
    sweep.stim_out     = '0;
    sweep.sample_valid = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          hcnt_nxt  = '0;
          sig_nxt   = '0;
        end
      end
      RUN: begin
        busy           = 1'b1;
        sweep.stim_out = idx[IN_W-1:0];
        if (hcnt == HOLD_LAST) begin
          sweep.sample_valid = 1'b1;
          sig_nxt  = {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ 16'(sweep.dut_resp);
          idx_nxt  = idx + 1'b1;
          hcnt_nxt = '0;
          // Extra index bit lets the last vector complete without wrapping.
          if (idx == LAST_IDX) state_nxt = DONE;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The index always equals the number of absorbed vectors, so it doubles as vec_count.
  assign signature = sig;
  assign vec_count = idx;

endmodule

// File: tb/tb_stim_sweep_gen.sv
// Directed bench for stim_sweep_gen: three instances cover the default sweep, a tiny
// hand-computed sweep and a multi-cycle hold; reset abort and held start are exercised on the first.
module tb_stim_sweep_gen;

  logic clk;
  logic rst;
  logic start0, start1, start2;
  logic mode0;

  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [15:0] sig0, sig1, sig2;
  logic [6:0]  vec0, vec2;
  logic [2:0]  vec1;

  int errors = 0;
  int checks = 0;

  logic [15:0] tab1 [4] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};

  function automatic logic [2:0] ref_fn(input logic [5:0] x);
    return {^x, (x[5] & x[0]) | x[2], x[1] ^ x[4]};
  endfunction

  function automatic logic [15:0] golden();
    logic [15:0] s;
    s = 16'h0000;
    for (int n = 0; n < 64; n++)
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, ref_fn(6'(n))};
    return s;
  endfunction

  stim_sweep_gen_if #(.IN_W(6), .OUT_W(3)) if0 ();
  stim_sweep_gen_if #(.IN_W(2), .OUT_W(1)) if1 ();
  stim_sweep_gen_if #(.IN_W(6), .OUT_W(3)) if2 ();

  assign if0.dut_resp = mode0 ? ref_fn(if0.stim_out) : 3'b000;
  assign if1.dut_resp = 1'b1;
  assign if2.dut_resp = ref_fn(if2.stim_out);

  stim_sweep_gen #(.IN_W(6), .OUT_W(3), .HOLD(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .sweep(if0.master),
    .busy(busy0), .done(done0), .signature(sig0), .vec_count(vec0));

  stim_sweep_gen #(.IN_W(2), .OUT_W(1), .HOLD(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sweep(if1.master),
    .busy(busy1), .done(done1), .signature(sig1), .vec_count(vec1));

  stim_sweep_gen #(.IN_W(6), .OUT_W(3), .HOLD(3)) u2 (
    .clk(clk), .rst(rst), .start(start2), .sweep(if2.master),
    .busy(busy2), .done(done2), .signature(sig2), .vec_count(vec2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_stim"}, 32'(if0.stim_out), 0);
    check({tag, "_sv"},   32'(if0.sample_valid), 0);
    check({tag, "_busy"}, 32'(busy0), 0);
    check({tag, "_done"}, 32'(done0), 0);
    check({tag, "_sig"},  32'(sig0), 0);
    check({tag, "_vec"},  32'(vec0), 0);
  endtask

  initial begin
    int n;
    logic [15:0] gold;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; mode0 = 1'b0;
    gold = golden();
    repeat (2) tick();
    rst = 1'b0;
    check_reset0("reset");

    // rst wins over start in IDLE
    rst = 1'b1; start0 = 1'b1;
    tick();
    check("rststart_busy", 32'(busy0), 0);
    check("rststart_done", 32'(done0), 0);
    rst = 1'b0; start0 = 1'b0;
    tick();
    check("rststart_idle", 32'(busy0), 0);

    // default sweep, response tied low
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    while (busy0 && n < 1000) begin
      check("t1_stim", 32'(if0.stim_out), 32'(n[5:0]));
      check("t1_sv", 32'(if0.sample_valid), 1);
      n++;
      tick();
    end
    check("t1_busy_len", n, 64);
    check("t1_done", 32'(done0), 1);
    check("t1_stim_done", 32'(if0.stim_out), 0);
    check("t1_sv_done", 32'(if0.sample_valid), 0);
    check("t1_sig", 32'(sig0), 0);
    check("t1_vec", 32'(vec0), 64);
    tick();
    check("t1_done_held", 32'(done0), 1);
    check("t1_vec_held", 32'(vec0), 64);

    // 2-bit sweep, response tied high
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_busy", 32'(busy1), 1);
      check("t2_sv", 32'(if1.sample_valid), 1);
      check("t2_stim", 32'(if1.stim_out), i);
      tick();
      check("t2_sig", 32'(sig1), 32'(tab1[i]));
      check("t2_vec", 32'(vec1), i + 1);
    end
    check("t2_done", 32'(done1), 1);
    check("t2_busy_end", 32'(busy1), 0);

    // HOLD=3 with reference block
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (busy2 && n < 1000) begin
      check("t3_stim", 32'(if2.stim_out), n / 3);
      check("t3_sv", 32'(if2.sample_valid), (n % 3 == 2) ? 1 : 0);
      n++;
      tick();
    end
    check("t3_busy_len", n, 192);
    check("t3_sig", 32'(sig2), 32'(gold));
    check("t3_vec", 32'(vec2), 64);
    check("t3_done", 32'(done2), 1);

    // reset mid-sweep, then a clean rerun
    mode0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t4_vec_clr", 32'(vec0), 0);
    check("t4_sig_clr", 32'(sig0), 0);
    n = 0;
    while (if0.stim_out != 6'd20 && n < 200) begin
      n++;
      tick();
    end
    check("t4_reach20", 32'(if0.stim_out), 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset0("t4_abort");
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n = 0;
    while (busy0 && n < 1000) begin
      n++;
      tick();
    end
    check("t4_busy_len", n, 64);
    check("t4_sig", 32'(sig0), 32'(gold));
    check("t4_vec", 32'(vec0), 64);
    check("t4_done", 32'(done0), 1);

    // start held high: no restart in RUN, single-cycle done, then a fresh run
    start0 = 1'b1;
    tick();
    n = 0;
    while (busy0 && n < 1000) begin
      n++;
      tick();
    end
    check("t5_busy_len", n, 64);
    check("t5_done", 32'(done0), 1);
    check("t5_sig", 32'(sig0), 32'(gold));
    tick();
    check("t5_done_drop", 32'(done0), 0);
    check("t5_rerun_busy", 32'(busy0), 1);
    check("t5_rerun_sig", 32'(sig0), 0);
    check("t5_rerun_vec", 32'(vec0), 0);
    check("t5_rerun_stim", 32'(if0.stim_out), 0);
    start0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
